serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_shift;
  logic [CW-1:0]    cnt;
  logic             br, a_i, b_i, d_i, br_next, last;

  // Current bit slice and the full-subtractor cell for it
  always_comb begin
    a_i       = a_q[cnt];
    b_i       = b_q[cnt];
    d_i       = a_i ^ b_i ^ br;
    br_next   = (~a_i & b_i) | (~a_i & br) | (b_i & br);
    res_shift = {d_i, res_q[WIDTH-1:1]};
    last      = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Result bits shift in from the top so bit 0 lands in place after WIDTH steps;
  // the visible outputs only change on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          res_q <= res_shift;
          br    <= br_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            diff <= res_shift;
            bout <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_i != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Honours SERIAL_SUB_OVERFLOW_EN to also check the ovf output.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE (called at a negedge) and leave the DUT in DONE
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                               input logic [7:0] ed, input logic eb, input logic eo);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; a = ~va; b = ~vb; bin = ~vbin;
    checkOutput("in_ready_run", 32'(in_ready), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      @(negedge clk);
      checkOutput("out_valid_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("out_valid_done", 32'(out_valid), 32'd1);
    checkOutput("diff", 32'(diff), 32'(ed));
    checkOutput("bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput("ovf", 32'(ovf), 32'(eo));
`else
    if (eo) begin end
`endif
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0); releaseResult();
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0); releaseResult();
    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); releaseResult();
    applyStimulus(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0); releaseResult();

    // Backpressure: result must hold and a new request must be ignored
    applyStimulus(8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_diff", 32'(diff), 32'hE1);
      checkOutput("bp_bout", 32'(bout), 32'd1);
    end
    in_valid = 1'b0;
    releaseResult();

    // Reset landing on the 4th RUN edge aborts the operation
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_bout", 32'(bout), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1); releaseResult();

    // Back-to-back with in_valid and out_ready tied high
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      a = ra; b = rb; bin = rbin;
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      repeat (WIDTH - 1) @(negedge clk);
      checkOutput("b2b_out_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_diff", 32'(diff), 32'(ref9[7:0]));
      checkOutput("b2b_bout", 32'(bout), 32'(ref9[8]));
`ifdef SERIAL_SUB_OVERFLOW_EN
      checkOutput("b2b_ovf", 32'(ovf), 32'((ra[7] != rb[7]) && (ref9[7] != ra[7])));
`endif
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
